// File: rtl/accum_arbiter_ctrl.sv
// accum_arbiter_ctrl: one N-bit accumulate datapath shared by two requesters.
// A round-robin arbiter grants a whole burst to one requester. The FSM clears
// the accumulator, adds LEN operands and then holds the result until it is acknowledged.
// Optional feature macro: ACCUM_SAT_EN (unsigned saturation instead of wrap).
//
// Operand handshake: during ACCUM, ready equals gnt, and ready of the
// non-granted requester is always 0. An operand transfers on a rising clk
// edge where valid[i] and ready[i] are both 1. ready does not depend on valid.
// Dropping req of the granted requester aborts the burst. An operand offered
// in that same cycle is not taken.
module accum_arbiter_ctrl #(
    parameter int N   = 8,
    parameter int LEN = 4
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic [1:0]   req,
    input  logic [1:0]   valid,
    input  logic [N-1:0] data0,
    input  logic [N-1:0] data1,
    output logic [1:0]   ready,
    output logic [1:0]   gnt,
    output logic         busy,
    output logic [N-1:0] result,
    output logic         carry,
    output logic         overflow,
    output logic         done,
    output logic         done_id,
    input  logic         ack,
    output logic [1:0]   dbg_state
);

    localparam int CW = $clog2(LEN + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          rr_ptr;

    logic          g;
    logic          win;
    logic [N-1:0]  data_g;
    logic [N:0]    sum;
    logic          ovf_step;
    logic [N-1:0]  add_val;
    logic          accept;
    logic          abort;
    logic          last;

    // Index of the requester that currently holds the grant.
    assign g      = gnt[1];
    assign data_g = g ? data1 : data0;

    // Arbitration: a sole requester wins outright, and a tie goes to rr_ptr.
    always_comb begin
        win = rr_ptr;
        if (req == 2'b01)
            win = 1'b0;
        else if (req == 2'b10)
            win = 1'b1;
    end

    // Adder with carry-out. Signed overflow occurs when the operand signs agree but the sum sign differs.
    always_comb begin
        sum      = {1'b0, result} + {1'b0, data_g};
        ovf_step = (result[N-1] == data_g[N-1]) && (sum[N-1] != result[N-1]);
`ifdef ACCUM_SAT_EN
        add_val  = sum[N] ? {N{1'b1}} : sum[N-1:0];
`else
        add_val  = sum[N-1:0];
`endif
    end

    // Handshake decode for the ACCUM state.
    always_comb begin
        ready  = (state == ACCUM) ? gnt : 2'b00;
        abort  = (state == ACCUM) && !req[g];
        accept = (state == ACCUM) && req[g] && valid[g];
        last   = (cnt == CW'(LEN - 1));
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    // Burst FSM with the accumulator, sticky flags and the round-robin pointer.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state    <= IDLE;
            gnt      <= 2'b00;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
            done_id  <= 1'b0;
            cnt      <= '0;
            rr_ptr   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        state    <= ACCUM;
                        gnt      <= win ? 2'b10 : 2'b01;
                        result   <= '0;
                        carry    <= 1'b0;
                        overflow <= 1'b0;
                        cnt      <= '0;
                    end
                end
                ACCUM: begin
                    if (abort) begin
                        state  <= IDLE;
                        gnt    <= 2'b00;
                        rr_ptr <= ~g;
                    end else if (accept) begin
                        result   <= add_val;
                        carry    <= carry | sum[N];
                        overflow <= overflow | ovf_step;
                        cnt      <= cnt + CW'(1);
                        if (last) begin
                            state   <= DONE;
                            gnt     <= 2'b00;
                            done    <= 1'b1;
                            done_id <= g;
                            rr_ptr  <= ~g;
                        end
                    end
                end
                DONE: begin
                    if (ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 2'b00;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accum_arbiter_ctrl.sv
// tb_accum_arbiter_ctrl: randomized bench for accum_arbiter_ctrl.
// Expected bursts come from plain integer arithmetic over the operand list.
// The grant winner comes from a "last served" rule.
module tb_accum_arbiter_ctrl;
    localparam int N   = 8;
    localparam int LEN = 4;

    logic         clk;
    logic         aclr;
    logic [1:0]   req;
    logic [1:0]   valid;
    logic [N-1:0] data0;
    logic [N-1:0] data1;
    logic [1:0]   ready;
    logic [1:0]   gnt;
    logic         busy;
    logic [N-1:0] result;
    logic         carry;
    logic         overflow;
    logic         done;
    logic         done_id;
    logic         ack;
    logic [1:0]   dbg_state;

    int errors;
    int checks;
    int last_served;
    logic [N-1:0] ops[LEN];
    logic [N-1:0] exp_q[$];

    accum_arbiter_ctrl #(.N(N), .LEN(LEN)) dut (
        .clk(clk), .aclr(aclr), .req(req), .valid(valid),
        .data0(data0), .data1(data1), .ready(ready), .gnt(gnt),
        .busy(busy), .result(result), .carry(carry), .overflow(overflow),
        .done(done), .done_id(done_id), .ack(ack), .dbg_state(dbg_state)
    );

    // Clock generation.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] oh(input int w);
        return (w == 1) ? 2'b10 : 2'b01;
    endfunction

    function automatic int pick(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
        return (last_served == 0) ? 1 : 0;
    endfunction

    function automatic int to_signed(input int x);
        return (x >= (1 << (N - 1))) ? x - (1 << N) : x;
    endfunction

    // Reference: sum of the first cnt operands, with the carry and signed-overflow flags.
    task automatic model(input int cnt, output logic [N-1:0] res, output logic c, output logic o);
        int acc;
        int s;
        int sa;
        acc = 0;
        c   = 1'b0;
        o   = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            s  = acc + int'(ops[i]);
            sa = to_signed(acc) + to_signed(int'(ops[i]));
            if (s >= (1 << N)) c = 1'b1;
            if (sa > (1 << (N - 1)) - 1 || sa < -(1 << (N - 1))) o = 1'b1;
`ifdef ACCUM_SAT_EN
            acc = (s >= (1 << N)) ? (1 << N) - 1 : s;
`else
            acc = s % (1 << N);
`endif
        end
        res = acc[N-1:0];
    endtask

    // One burst. abort_after < 0 means the burst runs to completion.
    task automatic run_burst(input logic [1:0] r, input int gmin, input int gmax,
                             input int abort_after, input bit abort_with_valid);
        int w;
        int n_acc;
        int edges;
        int gaps;
        int total_gaps;
        logic [N-1:0] er;
        logic [N-1:0] got_exp;
        logic ec;
        logic eo;
        w     = pick(r);
        n_acc = (abort_after < 0) ? LEN : abort_after;
        model(n_acc, er, ec, eo);
        exp_q.push_back(er);
        req   = r;
        edges = 0;
        total_gaps = 0;
        step();
        edges++;
        check("grant", gnt, oh(w));
        check("ready_grant", ready, oh(w));
        check("busy_grant", busy, 1);
        check("clear_result", result, 0);
        for (int i = 0; i < n_acc; i++) begin
            gaps = $urandom_range(gmin, gmax);
            total_gaps += gaps;
            for (int k = 0; k < gaps; k++) begin
                valid[w]   = 1'b0;
                valid[1-w] = 1'($urandom_range(0, 1));
                if (w == 0) data1 = N'($urandom); else data0 = N'($urandom);
                step();
                edges++;
                check("gap_no_done", done, 0);
                check("gap_ready", ready, oh(w));
            end
            valid[w]   = 1'b1;
            valid[1-w] = 1'($urandom_range(0, 1));
            if (w == 0) begin data0 = ops[i]; data1 = N'($urandom); end
            else begin data1 = ops[i]; data0 = N'($urandom); end
            step();
            edges++;
            if (i < LEN - 1) check("mid_no_done", done, 0);
        end
        valid = 2'b00;
        if (abort_after >= 0) begin
            if (abort_with_valid) begin
                valid[w] = 1'b1;
                if (w == 0) data0 = 8'h5A; else data1 = 8'h5A;
            end
            req = 2'b00;
            step();
            valid = 2'b00;
            got_exp = exp_q.pop_front();
            check("abort_busy", busy, 0);
            check("abort_gnt", gnt, 0);
            check("abort_done", done, 0);
            check("abort_result", result, got_exp);
            check("abort_carry", carry, ec);
            check("abort_ovf", overflow, eo);
            last_served = w;
            step();
            check("abort_stay_idle", done, 0);
            return;
        end
        got_exp = exp_q.pop_front();
        check("done", done, 1);
        check("done_latency", edges, 1 + LEN + total_gaps);
        check("done_gnt", gnt, 0);
        check("done_ready", ready, 0);
        check("result", result, got_exp);
        check("carry", carry, ec);
        check("overflow", overflow, eo);
        check("done_id", done_id, w);
        last_served = w;
        repeat ($urandom_range(0, 2)) begin
            step();
            check("done_hold", done, 1);
            check("result_hold", result, got_exp);
        end
        ack = 1'b1;
        req = 2'b00;
        step();
        ack = 1'b0;
        check("ack_done", done, 0);
        check("ack_busy", busy, 0);
    endtask

    task automatic set_ops(input int a, input int b, input int c, input int d);
        ops[0] = N'(a); ops[1] = N'(b); ops[2] = N'(c); ops[3] = N'(d);
    endtask

    // Main sequence: reset, directed cases, then randomized bursts.
    initial begin
        errors = 0;
        checks = 0;
        last_served = -1;
        aclr = 1'b1; req = 2'b00; valid = 2'b00; data0 = '0; data1 = '0; ack = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_gnt", gnt, 0);
        check("rst_ready", ready, 0);
        check("rst_result", result, 0);
        check("rst_done", done, 0);
        aclr = 1'b0;
        step();

        set_ops(10, 20, 30, 40);
        run_burst(2'b01, 0, 0, -1, 0);
        set_ops(8'hF0, 8'h20, 8'h01, 8'h00);
        run_burst(2'b01, 0, 1, -1, 0);
        set_ops(8'h7F, 8'h01, 0, 0);
        run_burst(2'b01, 3, 3, -1, 0);

        // Ties alternate, and the first tie after a reset favours requester 0.
        last_served = -1;
        aclr = 1'b1; #1; aclr = 1'b0;
        step();
        for (int t = 0; t < 3; t++) begin
            set_ops($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            run_burst(2'b11, 0, 1, -1, 0);
        end

        // Abort after two accepts with an operand offered alongside the drop.
        set_ops(8'h11, 8'h22, 8'h33, 8'h44);
        run_burst(2'b01, 0, 0, 2, 1);

        // Asynchronous clear in the middle of a burst.
        req = 2'b10;
        step();
        valid = 2'b10; data1 = 8'h33;
        step();
        #2 aclr = 1'b1; req = 2'b00; valid = 2'b00;
        #1;
        check("aclr_busy", busy, 0);
        check("aclr_gnt", gnt, 0);
        check("aclr_ready", ready, 0);
        check("aclr_result", result, 0);
        check("aclr_flags", {carry, overflow, done, done_id}, 0);
        #1 aclr = 1'b0;
        last_served = -1;
        step();
        set_ops(1, 2, 3, 4);
        run_burst(2'b11, 0, 0, -1, 0);

        for (int b = 0; b < 30; b++) begin
            set_ops($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
            if ($urandom_range(0, 4) == 0)
                run_burst(2'($urandom_range(1, 3)), 0, 2, $urandom_range(0, LEN - 1), 1'($urandom_range(0, 1)));
            else
                run_burst(2'($urandom_range(1, 3)), 0, 2, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
